// File: rtl/debug_pkg.sv
// Shared FSM encodings and button bit positions for the front-panel debug controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debug_pkg;

  typedef logic [1:0] state_t;

  localparam state_t HALT = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t STEP = 2'd2;

  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_PG_UP = 2;
  localparam int BTN_PG_DN = 3;

endpackage

// File: rtl/debug_ctrl_btn_edge.sv
// Rising-edge detector for debounced button levels; one press per low-to-high transition.
// Latency: press is combinational from btns against the previous-cycle level.
// Backpressure: none; a press is a single-cycle event and is lost if unused.
module btn_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btns,
  output logic [N-1:0] press
);

  logic [N-1:0] btn_q;
  logic [N-1:0] btn_d;

  // Previous-level register follows the buttons every cycle.
  always_comb begin
    btn_d = btns;
  end

  // Resets to all ones so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= '1;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign press = btns & ~btn_q;

endmodule

// File: rtl/debug_ctrl.sv
// Front-panel run/halt/step/breakpoint controller gating the core, plus display page select.
// Latency: 1 clk from button press to cpu_en/halted/leds; debug is 1 clk from view, 2 clk from page press.
// Backpressure: none; buttons are events, cpu_en is a free-running enable.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int W       = 16,
  parameter int NPAGE   = 4,
  parameter int RUN_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         btns,
  input  logic [W-1:0]       pc,
  input  logic               bp_en,
  input  logic [W-1:0]       bp_addr,
  input  logic [W*NPAGE-1:0] view,
  output logic               cpu_en,
  output logic               halted,
  output logic [W-1:0]       debug,
  output logic [3:0]         leds
);

  localparam int PW = $clog2(NPAGE);

  logic [3:0]    press;
  state_t        state_q, state_d;
  logic          cpu_en_q, cpu_en_d;
  logic          halted_q, halted_d;
  logic          bp_hit_q, bp_hit_d;
  logic          skip_bp_q, skip_bp_d;
  logic [PW-1:0] page_q, page_d;
  logic [W-1:0]  debug_q, debug_d;
  logic          slot;
  logic          run_act;
  logic          brk;
  logic          fire;

  btn_edge #(.N(4)) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btns  (btns),
    .press (press)
  );

  // Enable-slot divider; with RUN_DIV=1 every RUN cycle is a slot and no counter exists.
  if (RUN_DIV > 1) begin : g_div
    localparam int CW = $clog2(RUN_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(RUN_DIV - 1);
    logic [CW-1:0] div_cnt_q, div_cnt_d;

    // Count while running, wrap on the slot, hold at zero outside RUN.
    always_comb begin
      div_cnt_d = div_cnt_q + CW'(1);
      if (state_q != RUN || slot) begin
        div_cnt_d = '0;
      end
    end

    // Divider register.
    always_ff @(posedge clk) begin
      if (rst) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_d;
      end
    end

    assign slot = (div_cnt_q == LAST);
  end else begin : g_nodiv
    assign slot = 1'b1;
  end

  // A run-halt press pre-empts the slot; the first slot after a resume never breaks.
  assign run_act = (state_q == RUN) && !press[BTN_RUN] && slot;
  assign brk     = run_act && bp_en && (pc == bp_addr) && !skip_bp_q;
  assign fire    = run_act && !brk;

  // Next-state logic: run wins over step; STEP lasts one cycle; RUN leaves on press or breakpoint.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: begin
        if (press[BTN_RUN]) begin
          state_d = RUN;
        end else if (press[BTN_STEP]) begin
          state_d = STEP;
        end
      end
      STEP:    state_d = HALT;
      RUN: begin
        if (press[BTN_RUN] || brk) begin
          state_d = HALT;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // Registered outputs and sticky flags derived from the transition being taken.
  always_comb begin
    cpu_en_d  = fire || (state_d == STEP);
    halted_d  = (state_d == HALT);
    bp_hit_d  = bp_hit_q;
    skip_bp_d = skip_bp_q;
    if (state_q == HALT && press[BTN_RUN]) begin
      bp_hit_d  = 1'b0;
      skip_bp_d = 1'b1;
    end
    if (brk) begin
      bp_hit_d = 1'b1;
    end
    if (fire) begin
      skip_bp_d = 1'b0;
    end
  end

  // Page select wraps modulo NPAGE; simultaneous up and down cancel.
  always_comb begin
    page_d = page_q;
    if (press[BTN_PG_UP] && !press[BTN_PG_DN]) begin
      page_d = page_q + PW'(1);
    end else if (press[BTN_PG_DN] && !press[BTN_PG_UP]) begin
      page_d = page_q - PW'(1);
    end
    debug_d = view[page_q*W +: W];
  end

  // State register for FSM, flags, page and display word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HALT;
      cpu_en_q  <= 1'b0;
      halted_q  <= 1'b1;
      bp_hit_q  <= 1'b0;
      skip_bp_q <= 1'b0;
      page_q    <= '0;
      debug_q   <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      halted_q  <= halted_d;
      bp_hit_q  <= bp_hit_d;
      skip_bp_q <= skip_bp_d;
      page_q    <= page_d;
      debug_q   <= debug_d;
    end
  end

  assign cpu_en = cpu_en_q;
  assign halted = halted_q;
  assign debug  = debug_q;
  assign leds   = {bp_hit_q, (state_q == RUN), 2'(page_q)};

endmodule
